// File: rtl/adc_readout_pkg.sv
// Shared definitions for the ADC readout framer: state encoding, header bytes
// and the sample counter width.
package adc_readout_pkg;

    localparam int unsigned CntWidth = 13;

    localparam logic [7:0] Hdr0 = 8'hA5;
    localparam logic [7:0] Hdr1 = 8'h5A;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StHdr   = 3'd1;
    localparam logic [2:0] StRd    = 3'd2;
    localparam logic [2:0] StWaitq = 3'd3;
    localparam logic [2:0] StSend  = 3'd4;
    localparam logic [2:0] StCks   = 3'd5;
    localparam logic [2:0] StRearm = 3'd6;

endpackage

// File: rtl/adc_readout.sv
// Reads one captured record from a non-show-ahead FIFO and frames it as
// A5 5A CH_ID <samples> <checksum> on a valid/ready byte stream.
module adc_readout
    import adc_readout_pkg::*;
#(
    parameter int unsigned SAMPLES = 4096,
    parameter logic [7:0]  CH_ID   = 8'h00
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tx_en,
    input  logic       cap_end,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_q,
    output logic       fifo_rdreq,
    output logic       cap_bg,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       underrun
);

    localparam logic [CntWidth-1:0] SamplesC = CntWidth'(SAMPLES);

    logic [2:0]          state_q, state_d;
    logic [1:0]          hdr_idx_q, hdr_idx_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [7:0]          cks_q, cks_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                cap_bg_q, cap_bg_d;
    logic                busy_q, busy_d;
    logic                underrun_q, underrun_d;
    logic                hs;

    assign hs = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        cnt_d       = cnt_q;
        cks_d       = cks_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cap_bg_d    = cap_bg_q;
        underrun_d  = underrun_q;
        unique case (state_q)
            StIdle: begin
                if (tx_en && cap_end) begin
                    state_d     = StHdr;
                    hdr_idx_d   = 2'd0;
                    out_data_d  = Hdr0;
                    out_valid_d = 1'b1;
                    cks_d       = 8'h00;
                    cnt_d       = '0;
                    underrun_d  = 1'b0;
                end
            end
            StHdr: begin
                if (hs) begin
                    if (hdr_idx_q == 2'd0) begin
                        out_data_d = Hdr1;
                        hdr_idx_d  = 2'd1;
                    end else if (hdr_idx_q == 2'd1) begin
                        out_data_d = CH_ID;
                        hdr_idx_d  = 2'd2;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = StRd;
                    end
                end
            end
            StRd: begin
                if (!fifo_empty) begin
                    state_d = StWaitq;
                end else begin
                    // Short record: close the frame with what was sent so far.
                    underrun_d  = 1'b1;
                    out_data_d  = cks_q;
                    out_valid_d = 1'b1;
                    state_d     = StCks;
                end
            end
            StWaitq: begin
                out_data_d  = fifo_q;
                cks_d       = cks_q + fifo_q;
                cnt_d       = cnt_q + 1'b1;
                out_valid_d = 1'b1;
                state_d     = StSend;
            end
            StSend: begin
                if (hs) begin
                    if (cnt_q == SamplesC) begin
                        out_data_d = cks_q;
                        state_d    = StCks;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = StRd;
                    end
                end
            end
            StCks: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    cap_bg_d    = 1'b1;
                    state_d     = StRearm;
                end
            end
            StRearm: begin
                if (!cap_end) begin
                    cap_bg_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            hdr_idx_q   <= 2'd0;
            cnt_q       <= '0;
            cks_q       <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            cap_bg_q    <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            cnt_q       <= cnt_d;
            cks_q       <= cks_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cap_bg_q    <= cap_bg_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end

    // Read is issued in the RD cycle so fifo_q is valid in WAITQ.
    assign fifo_rdreq = (state_q == StRd) && !fifo_empty;
    assign cap_bg     = cap_bg_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

endmodule

// File: doc/adc_readout.md
ADC_READOUT -- requirements
Module: ADC_readout

Interface
REQ-001 Parameter SAMPLES, default 4096, number of samples read from the capture FIFO per frame (1..8191).
REQ-002 Parameter CH_ID, default 8'h00, channel identifier byte sent in the frame header.
REQ-003 Clk  input  1  single clock for all logic, shared with the capture FIFO.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 tx_en  input  1  enables frame transmission; sampled only in IDLE.
REQ-006 cap_end  input  1  capture-complete level from the capture block (FIFO holds a full record).
REQ-007 fifo_empty  input  1  capture FIFO empty flag.
REQ-008 fifo_q  input  8  capture FIFO read data, valid the cycle after fifo_rdreq (non-show-ahead).
REQ-009 fifo_rdreq  output  1  capture FIFO read request, one-cycle pulse per sample.
REQ-010 cap_bg  output  1  re-arm request to the capture block.
REQ-011 out_data  output  8  outgoing byte stream.
REQ-012 out_valid  output  1  out_data holds a valid byte.
REQ-013 out_ready  input  1  downstream accepts the byte when out_valid and out_ready are both high.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 underrun  output  1  sticky flag: the FIFO emptied before SAMPLES bytes were read.

Function
REQ-016 FSM states: IDLE, HDR, RD, WAITQ, SEND, CKS, REARM.
REQ-017 IDLE -> HDR when tx_en=1 and cap_end=1 in the same cycle; in that cycle the checksum clears, the sample counter clears and underrun clears.
REQ-018 HDR sends bytes 8'hA5, 8'h5A, CH_ID in order; each byte advances only on an out_valid&&out_ready handshake; after CH_ID is accepted, HDR -> RD.
REQ-019 RD with fifo_empty=0: fifo_rdreq=1 for exactly one cycle, then -> WAITQ.
REQ-020 RD with fifo_empty=1: no read; underrun is set to 1; -> CKS.
REQ-021 WAITQ captures fifo_q into the output register, adds it to the 8-bit checksum (modulo 256), increments the 13-bit sample counter, and -> SEND; fifo_rdreq=0.
REQ-022 SEND holds out_valid=1. On handshake: if counter==SAMPLES -> CKS, else -> RD.
REQ-023 CKS presents the checksum byte (sum of all sent samples mod 256, headers excluded); on handshake -> REARM.
REQ-024 REARM holds cap_bg=1 until cap_end=0 is sampled, then -> IDLE with cap_bg=0 on the next cycle.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_valid are held stable; no FIFO read is issued.
REQ-026 out_valid is registered and never combinationally depends on out_ready; back-to-back handshakes on consecutive cycles are permitted in HDR.
REQ-027 Minimum per-sample throughput with out_ready tied high: 3 cycles (RD, WAITQ, SEND).
REQ-028 fifo_rdreq is never asserted while fifo_empty=1 and never asserted outside RD.
REQ-029 tx_en deassertion outside IDLE has no effect; the current frame completes.
REQ-030 A frame after an underrun still ends with CKS over the bytes actually sent, and then REARM.
REQ-031 busy = (state != IDLE), registered.

Reset
REQ-032 On Reset=1 at a clock edge: state=IDLE, fifo_rdreq=0, cap_bg=0, out_valid=0, out_data=0, busy=0, underrun=0, counter=0, checksum=0.
REQ-033 Reset mid-frame aborts immediately, and the next frame starts only by the REQ-017 condition; FIFO contents are not modified by this block.

Structure
REQ-034 Shared package ADC_pkg holds the state encoding, header constants 8'hA5/8'h5A, and the counter width (13).
REQ-035 The block is a single module; no sub-module is required.

Verification
REQ-036 SAMPLES=8, FIFO preloaded 1..8, cap_end=1, tx_en=1, out_ready=1 -> stream A5 5A 00 01..08 24, then cap_bg high until cap_end drops.
REQ-037 Same as REQ-036 with out_ready toggled randomly -> identical byte sequence, out_data stable while stalled, exactly 8 fifo_rdreq pulses.
REQ-038 SAMPLES=8, FIFO holds only 5 bytes (10,20,30,40,50) -> A5 5A 00 0A 14 1E 28 32 96, underrun=1, no rdreq while empty.
REQ-039 Reset asserted during the 4th sample of SEND -> the next cycle has all outputs at reset values; a new frame starts from A5 when the start condition recurs.
REQ-040 Samples FF x 4 (SAMPLES=4) -> checksum FC (wrap-around); tx_en=0 with cap_end=1 -> stays IDLE, out_valid=0.
